// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types and constants for param_datapath
// Contents: ALU operation encodings, memory handshake states, flag bit indices.
package dp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_PASSB = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_XOR   = 3'd5,
        ALU_SHL1  = 3'd6,
        ALU_SHR1  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_RD_WAIT = 2'd1,
        MEM_WR_WAIT = 2'd2
    } mem_state_e;

    // flags vector is {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/dp_alu.sv
// rtl/dp_alu.sv - combinational ALU for param_datapath
// Ports: i_a (Y operand), i_b (bus operand), i_op (alu_op_e encoding),
//        o_result (DW-bit result), o_flags ({V,C,N,Z}).
module dp_alu
    import dp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic [DW-1:0] o_result,
    output logic [3:0]    o_flags
);

    logic [DW-1:0] w_b_eff;
    logic          w_cin;
    logic [DW:0]   w_sum;
    logic          w_c;
    logic          w_v;

    always_comb begin
        // SUB reuses the adder as A + ~B + 1 so carry/overflow come out uniformly
        w_b_eff  = (alu_op_e'(i_op) == ALU_SUB) ? ~i_b : i_b;
        w_cin    = (alu_op_e'(i_op) == ALU_SUB);
        w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{DW{1'b0}}, w_cin};
        o_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (alu_op_e'(i_op))
            ALU_ADD, ALU_SUB: begin
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = (i_a[DW-1] == w_b_eff[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
            end
            ALU_PASSB: o_result = i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SHL1: begin
                o_result = {i_b[DW-2:0], 1'b0};
                w_c      = i_b[DW-1];
            end
            ALU_SHR1: begin
                o_result = {1'b0, i_b[DW-1:1]};
                w_c      = i_b[0];
            end
            default: o_result = '0;
        endcase
        o_flags         = '0;
        o_flags[FLAG_V] = w_v;
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_N] = o_result[DW-1];
        o_flags[FLAG_Z] = (o_result == '0);
    end

endmodule

// File: rtl/param_datapath.sv
// rtl/param_datapath.sv - parametrised multi-cycle CPU datapath with memory handshake
// Ports: clk/rst_n (sync active-low reset); ld* load strobes; t*/thash* one-hot
//        bus source enables; rchoosein/rchooseout register indices; funSel ALU op;
//        mem_rd/mem_wr request pulses; mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/
//        mem_ack memory handshake; busy, ir, flags {V,C,N,Z}, sticky bus_err.
module param_datapath
    import dp_pkg::*;
#(
    parameter int          DW      = 16,
    parameter int          NREG    = 8,
    parameter int          RAW     = $clog2(NREG),
    parameter logic [DW-1:0] SP_INIT = {DW{1'b1}}
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ldMAR,
    input  logic           ldMDR,
    input  logic           ldIR,
    input  logic           ldPC,
    input  logic           ldSP,
    input  logic           ldYreg,
    input  logic           ldZ,
    input  logic           ldR,
    input  logic [RAW-1:0] rchoosein,
    input  logic [RAW-1:0] rchooseout,
    input  logic           tMDR,
    input  logic           tPC,
    input  logic           tSP,
    input  logic           treg,
    input  logic           tZ,
    input  logic           thash2,
    input  logic           thash4,
    input  logic [2:0]     funSel,
    input  logic           mem_rd,
    input  logic           mem_wr,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ack,
    output logic           busy,
    output logic [DW-1:0]  ir,
    output logic [3:0]     flags,
    output logic           bus_err
);

    localparam logic [DW-1:0] C_TWO  = DW'(2);
    localparam logic [DW-1:0] C_FOUR = DW'(4);

    logic [DW-1:0] r_mar, r_mdr, r_ir, r_pc, r_sp, r_y, r_z;
    logic [3:0]    r_flags;
    logic [DW-1:0] r_rf [NREG];
    mem_state_e    r_state;
    logic          r_mem_req, r_mem_we, r_bus_err;

    logic [6:0]    w_src;
    logic          w_multi;
    logic [DW-1:0] w_bus;
    logic [DW-1:0] w_alu_res;
    logic [3:0]    w_alu_flags;

    // Two or more enables: clearing the lowest set bit leaves something behind.
    assign w_src   = {tMDR, tPC, tSP, treg, tZ, thash2, thash4};
    assign w_multi = |(w_src & (w_src - 7'd1));

    always_comb begin
        w_bus = '0;
        if (!w_multi) begin
            w_bus = ({DW{tMDR}}   & r_mdr)
                  | ({DW{tPC}}    & r_pc)
                  | ({DW{tSP}}    & r_sp)
                  | ({DW{treg}}   & r_rf[rchooseout])
                  | ({DW{tZ}}     & r_z)
                  | ({DW{thash2}} & C_TWO)
                  | ({DW{thash4}} & C_FOUR);
        end
    end

    dp_alu #(.DW(DW)) u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_op     (funSel),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mar     <= '0;
            r_mdr     <= '0;
            r_ir      <= '0;
            r_pc      <= '0;
            r_sp      <= SP_INIT;
            r_y       <= '0;
            r_z       <= '0;
            r_flags   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (ldMAR)  r_mar <= w_bus;
            if (ldIR)   r_ir  <= w_bus;
            if (ldPC)   r_pc  <= w_bus;
            if (ldSP)   r_sp  <= w_bus;
            if (ldYreg) r_y   <= w_bus;
            if (ldZ) begin
                r_z     <= w_alu_res;
                r_flags <= w_alu_flags;
            end
            // Read completion wins over a same-cycle ldMDR.
            if (r_state == MEM_RD_WAIT && mem_ack)
                r_mdr <= mem_rdata;
            else if (ldMDR)
                r_mdr <= w_bus;
            r_bus_err <= r_bus_err | w_multi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (ldR) begin
            r_rf[rchoosein] <= w_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MEM_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (mem_rd) begin
                        r_state   <= MEM_RD_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                    end else if (mem_wr) begin
                        r_state   <= MEM_WR_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                    end
                end
                MEM_RD_WAIT, MEM_WR_WAIT: begin
                    if (mem_ack) begin
                        r_state   <= MEM_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= MEM_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign busy      = (r_state != MEM_IDLE);
    assign ir        = r_ir;
    assign flags     = r_flags;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_param_datapath.sv
// tb/tb_param_datapath.sv - directed self-checking bench for param_datapath
module tb_param_datapath;

    localparam int DW = 16;
    localparam int NREG = 8;
    localparam int RAW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ldMAR, ldMDR, ldIR, ldPC, ldSP, ldYreg, ldZ, ldR;
    logic [RAW-1:0] rchoosein, rchooseout;
    logic           tMDR, tPC, tSP, treg, tZ, thash2, thash4;
    logic [2:0]     funSel;
    logic           mem_rd, mem_wr, mem_ack;
    logic [DW-1:0]  mem_rdata;
    logic           mem_req, mem_we, busy, bus_err;
    logic [DW-1:0]  mem_addr, mem_wdata, ir;
    logic [3:0]     flags;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    param_datapath #(.DW(DW), .NREG(NREG), .RAW(RAW), .SP_INIT(16'hFFFE)) dut (
        .clk(clk), .rst_n(rst_n),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP),
        .ldYreg(ldYreg), .ldZ(ldZ), .ldR(ldR),
        .rchoosein(rchoosein), .rchooseout(rchooseout),
        .tMDR(tMDR), .tPC(tPC), .tSP(tSP), .treg(treg), .tZ(tZ),
        .thash2(thash2), .thash4(thash4), .funSel(funSel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .ir(ir), .flags(flags), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        {ldMAR, ldMDR, ldIR, ldPC, ldSP, ldYreg, ldZ, ldR} = '0;
        {tMDR, tPC, tSP, treg, tZ, thash2, thash4} = '0;
        funSel = 3'd0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Copy a bus source into MAR so it becomes visible on mem_addr.
    task automatic peek_pc(input string tag, input logic [DW-1:0] exp);
        tPC = 1'b1; ldMAR = 1'b1; tick();
        check(tag, mem_addr, exp);
    endtask

    initial begin
        idle_inputs();
        rchoosein = '0; rchooseout = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // reset state
        check("rst_busy", busy, 0);
        check("rst_flags", flags, 0);
        check("rst_req", mem_req, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mar", mem_addr, 0);
        check("rst_mdr", mem_wdata, 0);
        check("rst_ir", ir, 0);
        tSP = 1'b1; ldMAR = 1'b1; tick();
        check("rst_sp", mem_addr, 16'hFFFE);
        peek_pc("rst_pc", 16'h0000);

        // Y=4, bus=2, SUB -> 2 with carry out (no borrow)
        thash4 = 1'b1; ldYreg = 1'b1; tick();
        thash2 = 1'b1; funSel = 3'd1; ldZ = 1'b1; tick();
        tZ = 1'b1; ldPC = 1'b1; tick();
        check("sub42_flags", flags, 4'b0100);
        peek_pc("sub42_pc", 16'h0002);

        // Y=2, bus=4, SUB -> FFFE, N=1 C=0
        thash2 = 1'b1; ldYreg = 1'b1; tick();
        thash4 = 1'b1; funSel = 3'd1; ldZ = 1'b1; tick();
        tZ = 1'b1; ldPC = 1'b1; tick();
        check("sub24_flags", flags, 4'b0010);
        peek_pc("sub24_pc", 16'hFFFE);

        // build 0x10 by shifting 4 left twice, load MAR
        thash4 = 1'b1; funSel = 3'd6; ldZ = 1'b1; tick();
        tZ = 1'b1; funSel = 3'd6; ldZ = 1'b1; tick();
        check("shl_flags", flags, 4'b0000);
        tZ = 1'b1; ldMAR = 1'b1; tick();
        check("mar_0x10", mem_addr, 16'h0010);
        check("flags_hold", flags, 4'b0000);

        // memory read, ack arrives in the fourth busy cycle
        busy_cnt = 0;
        mem_rd = 1'b1; tick();
        if (busy) busy_cnt++;
        check("rd_req", mem_req, 1);
        check("rd_we", mem_we, 0);
        mem_wr = 1'b1; tick();   // ignored while busy
        if (busy) busy_cnt++;
        tick(); if (busy) busy_cnt++;
        tick(); if (busy) busy_cnt++;
        check("rd_we_hold", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 16'd72; ldMDR = 1'b1; thash4 = 1'b1; tick();
        mem_ack = 1'b0; mem_rdata = '0;
        if (busy) busy_cnt++;
        tick(); if (busy) busy_cnt++;
        check("rd_busy_cycles", busy_cnt, 4);
        check("rd_mdr", mem_wdata, 16'd72);
        check("rd_req_done", mem_req, 0);

        // ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 16'h5555; tick();
        mem_ack = 1'b0;
        check("idle_ack_mdr", mem_wdata, 16'd72);
        check("idle_ack_busy", busy, 0);

        // memory write; read wins when both pulse
        mem_wr = 1'b1; tick();
        check("wr_we", mem_we, 1);
        check("wr_busy", busy, 1);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("wr_done", busy, 0);
        mem_rd = 1'b1; mem_wr = 1'b1; tick();
        check("both_we", mem_we, 0);
        check("both_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'd72; tick(); mem_ack = 1'b0;

        // register file write then read back through PC
        tMDR = 1'b1; ldR = 1'b1; rchoosein = 3'd2; tick();
        treg = 1'b1; rchooseout = 3'd2; ldPC = 1'b1; tick();
        peek_pc("rf_pc", 16'd72);
        for (int i = 0; i < NREG; i++) begin
            if (i != 2) begin
                treg = 1'b1; rchooseout = RAW'(i); ldMAR = 1'b1; tick();
                check($sformatf("rf_zero_%0d", i), mem_addr, 0);
            end
        end

        // no enable drives zero
        tZ = 1'b1; ldMAR = 1'b1; tick();
        ldMAR = 1'b1; tick();
        check("bus_none", mem_addr, 0);
        check("bus_none_err", bus_err, 0);

        // contention
        tMDR = 1'b1; ldMAR = 1'b1; tick();
        tPC = 1'b1; tSP = 1'b1; ldMAR = 1'b1; tick();
        check("contention_mar", mem_addr, 0);
        check("contention_err", bus_err, 1);
        tick(); tick();
        check("contention_sticky", bus_err, 1);

        // overflow: Y=7FFF, bus=1 via rf[5]
        thash2 = 1'b1; funSel = 3'd7; ldZ = 1'b1; tick();
        tZ = 1'b1; ldR = 1'b1; rchoosein = 3'd5; tick();
        tSP = 1'b1; funSel = 3'd7; ldZ = 1'b1; tick();
        check("shr_flags", flags, 4'b0000);
        tZ = 1'b1; ldYreg = 1'b1; tick();
        treg = 1'b1; rchooseout = 3'd5; funSel = 3'd0; ldZ = 1'b1; tick();
        check("ovf_flags", flags, 4'b1010);
        tZ = 1'b1; ldMAR = 1'b1; tick();
        check("ovf_z", mem_addr, 16'h8000);

        // reset during RD_WAIT aborts; a late ack is ignored
        mem_rd = 1'b1; tick();
        check("abort_pre_req", mem_req, 1);
        rst_n = 1'b0; tick();
        check("abort_req", mem_req, 0);
        check("abort_busy", busy, 0);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'h1234; tick();
        mem_ack = 1'b0;
        check("abort_mdr", mem_wdata, 0);
        check("abort_bus_err", bus_err, 0);
        check("abort_flags", flags, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
